// File: rtl/pong_pkg.sv
// Shared geometry defaults, game state encoding and the saturating step helper
// used by the pong game-state engine and its paddle sub-blocks.
package pong_pkg;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_PADDLE_W     = 8;
  localparam int DEF_PADDLE_H     = 64;
  localparam int DEF_BALL_SIZE    = 8;
  localparam int DEF_PAD_L_X      = 16;
  localparam int DEF_PAD_R_X      = 616;
  localparam int DEF_PADDLE_STEP  = 4;
  localparam int DEF_BALL_STEP    = 2;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_WIN_SCORE    = 9;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Moves a 10-bit position by step toward 0 (up) or toward max_pos (down),
  // stopping exactly at the limit instead of wrapping.
  function automatic logic [9:0] sat_move(
    input logic [9:0] pos,
    input logic [9:0] step,
    input logic       up,
    input logic [9:0] max_pos
  );
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (up) begin
      return (pos >= step) ? (pos - step) : 10'd0;
    end
    return (sum >= {1'b0, max_pos}) ? max_pos : sum[9:0];
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle's vertical position register; moves once per frame tick from
// its two buttons, saturating at the top and bottom of the playfield.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int STEP   = DEF_PADDLE_STEP,
  parameter int MAX_Y  = DEF_V_ACTIVE - DEF_PADDLE_H,
  parameter int INIT_Y = (DEF_V_ACTIVE - DEF_PADDLE_H) / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       up,
  input  logic       dn,
  input  logic       freeze,
  output logic [9:0] y
);

  // NOTE: state updates use non-blocking assignment so every register in the
  // design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      y <= 10'(INIT_Y);
    end else if (tick && !freeze && (up ^ dn)) begin
      y <= sat_move(y, 10'(STEP), up, 10'(MAX_Y));
    end
  end

endmodule

// File: rtl/pong_game.sv
// Pong game-state engine: once per frame (first blanking line) advances the
// ball, both paddles, the scores and the SERVE/PLAY/POINT/OVER sequence.
module pong_game
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PAD_L_X      = DEF_PAD_L_X,
  parameter int PAD_R_X      = DEF_PAD_R_X,
  parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
  parameter int BALL_STEP    = DEF_BALL_STEP,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       up_l,
  input  logic       dn_l,
  input  logic       up_r,
  input  logic       dn_r,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       serving,
  output logic       game_over
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0] CENTRE_X = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] CENTRE_Y = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] PAD_INIT = 10'((V_ACTIVE - PADDLE_H) / 2);

  // Signed 11-bit copies of the geometry so next-position compares see underflow.
  localparam logic signed [10:0] STEP_S  = 11'(BALL_STEP);
  localparam logic signed [10:0] SIZE_S  = 11'(BALL_SIZE);
  localparam logic signed [10:0] Y_MAX_S = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] X_MAX_S = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] L_X_S   = 11'(PAD_L_X);
  localparam logic signed [10:0] L_FACE_S = 11'(PAD_L_X + PADDLE_W);
  localparam logic signed [10:0] R_X_S   = 11'(PAD_R_X);
  localparam logic signed [10:0] R_END_S = 11'(PAD_R_X + PADDLE_W);

  localparam logic [9:0] Y_MAX   = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] L_FACE  = 10'(PAD_L_X + PADDLE_W);
  localparam logic [9:0] R_STOP  = 10'(PAD_R_X - BALL_SIZE);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);

  state_e             state;
  logic [CNT_W-1:0]   serve_cnt;
  logic               dx_pos;
  logic               dy_pos;
  logic               point_to_r;

  logic               tick;
  logic               frozen;
  logic signed [10:0] nx;
  logic signed [10:0] ny;
  logic               ov_l;
  logic               ov_r;
  logic               hit_l;
  logic               hit_r;
  logic               miss_l;
  logic               miss_r;

  assign tick      = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
  assign frozen    = (state == ST_OVER);
  assign serving   = (state == ST_SERVE);
  assign game_over = (state == ST_OVER);

  pong_paddle #(
    .STEP   (PADDLE_STEP),
    .MAX_Y  (V_ACTIVE - PADDLE_H),
    .INIT_Y ((V_ACTIVE - PADDLE_H) / 2)
  ) u_pad_l (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .up     (up_l),
    .dn     (dn_l),
    .freeze (frozen),
    .y      (pad_l_y)
  );

  pong_paddle #(
    .STEP   (PADDLE_STEP),
    .MAX_Y  (V_ACTIVE - PADDLE_H),
    .INIT_Y ((V_ACTIVE - PADDLE_H) / 2)
  ) u_pad_r (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .up     (up_r),
    .dn     (dn_r),
    .freeze (frozen),
    .y      (pad_r_y)
  );

  // Collision tests use the paddle positions as they stand before this tick.
  always_comb begin
    nx     = dx_pos ? ($signed({1'b0, ball_x}) + STEP_S) : ($signed({1'b0, ball_x}) - STEP_S);
    ny     = dy_pos ? ($signed({1'b0, ball_y}) + STEP_S) : ($signed({1'b0, ball_y}) - STEP_S);
    ov_l   = (({1'b0, ball_y} + 11'(BALL_SIZE)) > {1'b0, pad_l_y}) &&
             ({1'b0, ball_y} < ({1'b0, pad_l_y} + 11'(PADDLE_H)));
    ov_r   = (({1'b0, ball_y} + 11'(BALL_SIZE)) > {1'b0, pad_r_y}) &&
             ({1'b0, ball_y} < ({1'b0, pad_r_y} + 11'(PADDLE_H)));
    hit_l  = !dx_pos && (nx <= L_FACE_S) && ((nx + SIZE_S) > L_X_S) && ov_l;
    hit_r  = dx_pos && ((nx + SIZE_S) >= R_X_S) && (nx < R_END_S) && ov_r;
    miss_l = (nx <= 11'sd0);
    miss_r = (nx >= X_MAX_S);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SERVE;
      serve_cnt  <= '0;
      ball_x     <= CENTRE_X;
      ball_y     <= CENTRE_Y;
      dx_pos     <= 1'b1;
      dy_pos     <= 1'b1;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      point_to_r <= 1'b0;
    end else if (tick) begin
      unique case (state)
        ST_SERVE: begin
          if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            serve_cnt <= '0;
            state     <= ST_PLAY;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end

        ST_PLAY: begin
          if (ny <= 11'sd0) begin
            ball_y <= 10'd0;
            dy_pos <= 1'b1;
          end else if (ny >= Y_MAX_S) begin
            ball_y <= Y_MAX;
            dy_pos <= 1'b0;
          end else begin
            ball_y <= ny[9:0];
          end

          // Paddle hits outrank misses; a missed ball parks at the screen edge.
          if (hit_l) begin
            ball_x <= L_FACE;
            dx_pos <= 1'b1;
          end else if (hit_r) begin
            ball_x <= R_STOP;
            dx_pos <= 1'b0;
          end else if (miss_l) begin
            ball_x     <= 10'd0;
            score_r    <= score_r + 4'd1;
            point_to_r <= 1'b1;
            state      <= ST_POINT;
          end else if (miss_r) begin
            ball_x     <= X_MAX;
            score_l    <= score_l + 4'd1;
            point_to_r <= 1'b0;
            state      <= ST_POINT;
          end else begin
            ball_x <= nx[9:0];
          end
        end

        ST_POINT: begin
          if ((score_l == WIN) || (score_r == WIN)) begin
            state <= ST_OVER;
          end else begin
            ball_x <= CENTRE_X;
            ball_y <= CENTRE_Y;
            dx_pos <= !point_to_r;
            state  <= ST_SERVE;
          end
        end

        ST_OVER: begin
          state <= ST_OVER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game.sv
// Randomized bench for pong_game: a frame-level reference model built from
// the game rules predicts every output after each frame tick.
module tb_pong_game;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int PAD_MAX = 416;
  localparam int MAX_TICKS = 30000;

  localparam int PH_SERVE = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_POINT = 2;
  localparam int PH_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hcount = 10'd5;
  logic [9:0] vcount = 10'd5;
  logic       up_l = 1'b0, dn_l = 1'b0, up_r = 1'b0, dn_r = 1'b0;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic       serving, game_over;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, plain integers in screen pixels.
  int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_cnt, m_ph;
  bit m_left_lost;
  int n_hits = 0;

  pong_game dut (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .up_l      (up_l),
    .dn_l      (dn_l),
    .up_r      (up_r),
    .dn_r      (dn_r),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .pad_l_y   (pad_l_y),
    .pad_r_y   (pad_r_y),
    .score_l   (score_l),
    .score_r   (score_r),
    .serving   (serving),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ball_x"},    int'(ball_x),    m_bx);
    check({tag, ".ball_y"},    int'(ball_y),    m_by);
    check({tag, ".pad_l_y"},   int'(pad_l_y),   m_pl);
    check({tag, ".pad_r_y"},   int'(pad_r_y),   m_pr);
    check({tag, ".score_l"},   int'(score_l),   m_sl);
    check({tag, ".score_r"},   int'(score_r),   m_sr);
    check({tag, ".serving"},   int'(serving),   (m_ph == PH_SERVE) ? 1 : 0);
    check({tag, ".game_over"}, int'(game_over), (m_ph == PH_OVER) ? 1 : 0);
  endtask

  function automatic int paddle_next(input int p, input bit up, input bit dn);
    if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > PAD_MAX) ? PAD_MAX : p + 4;
    return p;
  endfunction

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0;
    m_cnt = 0; m_ph = PH_SERVE; m_left_lost = 1'b0;
  endtask

  task automatic model_tick(input bit ul, input bit dl, input bit ur, input bit dr);
    int nx, ny;
    bit ovl, ovr;
    if (m_ph == PH_OVER) return;
    case (m_ph)
      PH_SERVE: begin
        if (m_cnt == 59) begin m_cnt = 0; m_ph = PH_PLAY; end
        else m_cnt++;
      end
      PH_PLAY: begin
        nx  = m_bx + 2 * m_dx;
        ny  = m_by + 2 * m_dy;
        ovl = (m_by + 8 > m_pl) && (m_by < m_pl + 64);
        ovr = (m_by + 8 > m_pr) && (m_by < m_pr + 64);
        if (ny <= 0) begin m_by = 0; m_dy = 1; end
        else if (ny >= V_ACT - 8) begin m_by = V_ACT - 8; m_dy = -1; end
        else m_by = ny;
        if (m_dx < 0 && nx <= 24 && nx + 8 > 16 && ovl) begin
          m_bx = 24; m_dx = 1; n_hits++;
        end else if (m_dx > 0 && nx + 8 >= 616 && nx < 624 && ovr) begin
          m_bx = 608; m_dx = -1; n_hits++;
        end else if (nx <= 0) begin
          m_bx = 0; m_sr++; m_left_lost = 1'b1; m_ph = PH_POINT;
        end else if (nx >= H_ACT - 8) begin
          m_bx = H_ACT - 8; m_sl++; m_left_lost = 1'b0; m_ph = PH_POINT;
        end else m_bx = nx;
      end
      default: begin
        if (m_sl == 9 || m_sr == 9) m_ph = PH_OVER;
        else begin
          m_bx = 316; m_by = 236;
          m_dx = m_left_lost ? -1 : 1;
          m_ph = PH_SERVE;
        end
      end
    endcase
    m_pl = paddle_next(m_pl, ul, dl);
    m_pr = paddle_next(m_pr, ur, dr);
  endtask

  // Any raster position other than the tick point, plus button noise that
  // the DUT must ignore between ticks.
  task automatic idle_inputs();
    int h, v;
    h = $urandom_range(0, 799);
    v = $urandom_range(0, 524);
    if (h == 0 && v == V_ACT) v = V_ACT + 1;
    hcount = 10'(h);
    vcount = 10'(v);
    {up_l, dn_l, up_r, dn_r} = 4'($urandom_range(0, 15));
  endtask

  task automatic do_frame(input bit ul, input bit dl, input bit ur, input bit dr,
                          input string tag);
    @(negedge clk);
    hcount = 10'd0;
    vcount = 10'(V_ACT);
    {up_l, dn_l, up_r, dn_r} = {ul, dl, ur, dr};
    @(negedge clk);
    model_tick(ul, dl, ur, dr);
    idle_inputs();
    check_all(tag);
  endtask

  // Chase the ball with probability pct, otherwise press random buttons.
  task automatic pick_buttons(input int pad, input int pct, output bit up, output bit dn);
    int centre, target;
    if ($urandom_range(0, 99) < pct) begin
      centre = pad + 32;
      target = m_by + 4;
      up = (centre > target + 2);
      dn = (centre < target - 2);
    end else begin
      {up, dn} = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    bit ul, dl, ur, dr;
    int ticks;

    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    idle_inputs();

    // Serve hold with left paddle pushed to the top and right paddle double-pressed.
    for (int i = 1; i <= 60; i++) begin
      do_frame(1'b1, 1'b0, 1'b1, 1'b1, "serve_hold");
      if (i == 59) check("serving_at_59", int'(serving), 1);
    end
    check("pad_l_saturated", int'(pad_l_y), 0);
    check("pad_r_both_pressed", int'(pad_r_y), 208);
    check("serving_after_60", int'(serving), 0);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0, "first_move");
    check("first_move_x", int'(ball_x), 318);
    check("first_move_y", int'(ball_y), 238);

    // No tick for 1000 cycles: every output must hold.
    repeat (1000) begin
      @(negedge clk);
      idle_inputs();
    end
    check_all("no_tick_hold");

    // Random game until the model reaches OVER.
    ticks = 0;
    while (m_ph != PH_OVER && ticks < MAX_TICKS && n_bad < 50) begin
      pick_buttons(m_pl, 40, ul, dl);
      pick_buttons(m_pr, 40, ur, dr);
      do_frame(ul, dl, ur, dr, "play");
      ticks++;
    end
    check("game_reached_over", (m_ph == PH_OVER) ? 1 : 0, 1);
    $display("info: %0d ticks played, %0d paddle hits, final score %0d-%0d",
             ticks, n_hits, m_sl, m_sr);

    // Frozen in OVER under button activity.
    for (int i = 0; i < 20; i++) begin
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "over_frozen");
    end

    // Reset coincident with a tick must win and restore all reset values.
    @(negedge clk);
    hcount = 10'd0;
    vcount = 10'(V_ACT);
    {up_l, dn_l, up_r, dn_r} = 4'b1010;
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("reset_over_tick");
    reset = 1'b0;
    idle_inputs();

    // After reset the serve sequence restarts from zero.
    for (int i = 0; i < 70; i++) begin
      pick_buttons(m_pl, 50, ul, dl);
      pick_buttons(m_pr, 50, ur, dr);
      do_frame(ul, dl, ur, dr, "after_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
